// File: rtl/pm_noc_out_arb_pkg.sv
// Shared definitions for the PM-domain outbound NoC arbiter and its helpers.
package pm_noc_out_arb_pkg;

  localparam int MAX_REQ                    = 8;
  localparam int NOC_ASYNC_FIFO_PACKET_SIZE = 32;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // The burst marker is the packet MSB unless a user overrides it.
  function automatic int default_burst_bit(input int packet_size);
    return packet_size - 1;
  endfunction

endpackage

// File: rtl/pm_noc_out_arb_rr_pick.sv
// Rotate-priority encoder: first set bit of vec_i at or above ptr_i, wrapping modulo N.
module pm_noc_out_arb_rr_pick
  import pm_noc_out_arb_pkg::*;
#(
  parameter int N     = 2,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     vec_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     onehot_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [2*MAX_REQ-1:0] rotated;
  logic                 found;
  int                   pos;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    found    = 1'b0;
    pos      = 0;
    // Doubling the vector turns the wrap-around search into a plain shift.
    rotated  = (2*MAX_REQ)'({vec_i, vec_i}) >> ptr_i;
    for (int k = 0; k < MAX_REQ; k++) begin
      if (k < N && !found && rotated[k]) begin
        found = 1'b1;
        pos   = int'(ptr_i) + k;
        if (pos >= N) pos = pos - N;
      end
    end
    if (found) begin
      idx_o    = IDX_W'(pos);
      onehot_o = N'(1) << idx_o;
    end
  end

endmodule

// File: rtl/pm_noc_out_arb.sv
// Round-robin arbiter sharing the PM outbound NoC packet path; bursts hold the
// grant until their last packet or until the burst watchdog forces a release.
module pm_noc_out_arb
  import pm_noc_out_arb_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int PACKET_SIZE = NOC_ASYNC_FIFO_PACKET_SIZE,
  parameter int BURST_BIT   = default_burst_bit(PACKET_SIZE),
  parameter int MAX_BURST   = 16
) (
  input  logic                           clk_pm_i,
  input  logic                           reset_pm_i,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  input  logic [NUM_REQ*PACKET_SIZE-1:0] req_data_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  output logic                           out_valid_o,
  output logic [PACKET_SIZE-1:0]         out_data_o,
  input  logic                           out_ready_i,
  output logic [NUM_REQ-1:0]             grant_o,
  output logic                           burst_abort_o,
  input  logic                           burst_abort_clr_i
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_e             state_q;
  logic [IDX_W-1:0]       owner_q;
  logic [IDX_W-1:0]       rr_ptr_q;
  logic [7:0]             burst_cnt_q;
  logic                   out_valid_q;
  logic [PACKET_SIZE-1:0] out_data_q;
  logic                   burst_abort_q;

  logic [NUM_REQ-1:0]     pick_onehot;
  logic [IDX_W-1:0]       pick_idx;
  logic [NUM_REQ-1:0]     grant_vec;
  logic [NUM_REQ-1:0]     ready_vec;
  logic [IDX_W-1:0]       grant_idx;
  logic [IDX_W-1:0]       next_ptr;
  logic [PACKET_SIZE-1:0] sel_data;
  logic [7:0]             cnt_inc;
  logic                   can_accept;
  logic                   accept;
  logic                   burst_flag;
  logic                   force_release;

  pm_noc_out_arb_rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .vec_i    (req_valid_i),
    .ptr_i    (rr_ptr_q),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx)
  );

  always_comb begin
    grant_idx = (state_q == ARB_LOCKED) ? owner_q : pick_idx;
    grant_vec = (state_q == ARB_LOCKED) ? (NUM_REQ'(1) << owner_q) : pick_onehot;
    if (reset_pm_i) grant_vec = '0;

    // A full register can still take a packet in the cycle it drains.
    can_accept = !out_valid_q || out_ready_i;
    ready_vec  = can_accept ? grant_vec : '0;
    accept     = |(req_valid_i & ready_vec);

    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDX_W'(i) == grant_idx) sel_data = req_data_i[i*PACKET_SIZE +: PACKET_SIZE];
    end
    burst_flag = sel_data[BURST_BIT];

    next_ptr      = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
    cnt_inc       = burst_cnt_q + 8'd1;
    force_release = accept && (state_q == ARB_LOCKED) && burst_flag
                    && (cnt_inc == 8'(MAX_BURST));
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk_pm_i) begin
    if (reset_pm_i) begin
      state_q       <= ARB_IDLE;
      owner_q       <= '0;
      rr_ptr_q      <= '0;
      burst_cnt_q   <= '0;
      out_valid_q   <= 1'b0;
      // NOTE: the packet register is reset as well, since out_data_o must read zero in reset.
      out_data_q    <= '0;
      burst_abort_q <= 1'b0;
    end else begin
      if (can_accept) begin
        out_valid_q <= accept;
        if (accept) out_data_q <= sel_data;
      end

      if (force_release)          burst_abort_q <= 1'b1;
      else if (burst_abort_clr_i) burst_abort_q <= 1'b0;

      unique case (state_q)
        ARB_IDLE: begin
          if (accept) begin
            if (burst_flag) begin
              state_q     <= ARB_LOCKED;
              owner_q     <= grant_idx;
              burst_cnt_q <= 8'd1;
            end else begin
              rr_ptr_q <= next_ptr;
            end
          end
        end
        ARB_LOCKED: begin
          if (accept) begin
            if (!burst_flag || force_release) begin
              state_q     <= ARB_IDLE;
              rr_ptr_q    <= next_ptr;
              burst_cnt_q <= '0;
            end else begin
              burst_cnt_q <= cnt_inc;
            end
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign req_ready_o   = ready_vec;
  assign grant_o       = grant_vec;
  assign out_valid_o   = out_valid_q;
  assign out_data_o    = out_data_q;
  assign burst_abort_o = burst_abort_q;

endmodule

// File: tb/tb_pm_noc_out_arb.sv
// Self-checking bench for pm_noc_out_arb: directed table, corner sequences and
// randomized traffic compared against a cycle-level reference model.
module tb_pm_noc_out_arb;

  localparam int NREQ = 3;
  localparam int PW   = 16;
  localparam int BB   = 15;
  localparam int MAXB = 4;

  logic                 clk;
  logic                 rst;
  logic [NREQ-1:0]      v;
  logic [PW-1:0]        d [NREQ];
  logic [NREQ*PW-1:0]   req_data;
  logic                 ordy;
  logic                 clr;
  logic [NREQ-1:0]      req_ready_o;
  logic                 out_valid_o;
  logic [PW-1:0]        out_data_o;
  logic [NREQ-1:0]      grant_o;
  logic                 burst_abort_o;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: owner -1 means no burst lock is held.
  int            m_ptr, m_owner, m_cnt;
  bit            m_ov, m_abort;
  logic [PW-1:0] m_od;
  logic [NREQ-1:0] last_acc;
  logic [PW-1:0] sb [$];

  pm_noc_out_arb #(
    .NUM_REQ     (NREQ),
    .PACKET_SIZE (PW),
    .BURST_BIT   (BB),
    .MAX_BURST   (MAXB)
  ) dut (
    .clk_pm_i          (clk),
    .reset_pm_i        (rst),
    .req_valid_i       (v),
    .req_data_i        (req_data),
    .req_ready_o       (req_ready_o),
    .out_valid_o       (out_valid_o),
    .out_data_o        (out_data_o),
    .out_ready_i       (ordy),
    .grant_o           (grant_o),
    .burst_abort_o     (burst_abort_o),
    .burst_abort_clr_i (clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    req_data = '0;
    for (int i = 0; i < NREQ; i++) req_data[i*PW +: PW] = d[i];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_ptr = 0; m_owner = -1; m_cnt = 0;
    m_ov = 1'b0; m_od = '0; m_abort = 1'b0;
    last_acc = '0;
    sb.delete();
  endtask

  function automatic int model_grant();
    if (m_owner >= 0) return m_owner;
    for (int k = 0; k < NREQ; k++) begin
      int i = (m_ptr + k) % NREQ;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  // Compare the current cycle against the model, then advance one clock.
  task automatic cycle();
    int              g;
    bit              can, acc, forced;
    logic [NREQ-1:0] exp_g, exp_r;
    logic [PW-1:0]   pkt, exp_pkt;
    #1;
    g     = model_grant();
    exp_g = (rst || g < 0) ? '0 : NREQ'(1) << g;
    can   = !m_ov || ordy;
    exp_r = can ? exp_g : '0;
    check("grant", 32'(grant_o), 32'(exp_g));
    check("req_ready", 32'(req_ready_o), 32'(exp_r));
    check("out_valid", 32'(out_valid_o), 32'(m_ov));
    check("out_data", 32'(out_data_o), 32'(m_od));
    check("burst_abort", 32'(burst_abort_o), 32'(m_abort));
    if (!rst && out_valid_o && ordy) begin
      exp_pkt = (sb.size() > 0) ? sb.pop_front() : 'x;
      check("scoreboard", 32'(out_data_o), 32'(exp_pkt));
    end
    if (rst) begin
      model_reset();
    end else begin
      acc      = (g >= 0) && can && v[g];
      pkt      = (g >= 0) ? d[g] : '0;
      last_acc = acc ? NREQ'(1) << g : '0;
      forced   = 1'b0;
      if (can) begin
        m_ov = acc;
        if (acc) m_od = pkt;
      end
      if (acc) begin
        sb.push_back(pkt);
        if (m_owner < 0) begin
          if (pkt[BB]) begin m_owner = g; m_cnt = 1; end
          else m_ptr = (g + 1) % NREQ;
        end else begin
          m_cnt++;
          if (!pkt[BB]) begin
            m_owner = -1; m_ptr = (g + 1) % NREQ;
          end else if (m_cnt == MAXB) begin
            m_owner = -1; m_ptr = (g + 1) % NREQ; forced = 1'b1;
          end
        end
      end
      if (forced)   m_abort = 1'b1;
      else if (clr) m_abort = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [NREQ-1:0] valid;
    logic [PW-1:0]   d0;
    logic [PW-1:0]   d1;
    logic [NREQ-1:0] exp_grant;
    logic [NREQ-1:0] exp_ready;
    logic            exp_ov;
    logic [PW-1:0]   exp_od;
  } row_t;

  row_t tbl [14];

  initial begin
    // Single packet, fairness, then a 3-packet burst with a 2-cycle gap.
    tbl[0]  = '{3'b001, 16'h00A5, 16'h0000, 3'b001, 3'b001, 1'b0, 16'h0000};
    tbl[1]  = '{3'b000, 16'h00A5, 16'h0000, 3'b000, 3'b000, 1'b1, 16'h00A5};
    tbl[2]  = '{3'b011, 16'h0101, 16'h0202, 3'b010, 3'b010, 1'b0, 16'h00A5};
    tbl[3]  = '{3'b011, 16'h0101, 16'h0203, 3'b001, 3'b001, 1'b1, 16'h0202};
    tbl[4]  = '{3'b011, 16'h0102, 16'h0203, 3'b010, 3'b010, 1'b1, 16'h0101};
    tbl[5]  = '{3'b011, 16'h0102, 16'h0204, 3'b001, 3'b001, 1'b1, 16'h0203};
    tbl[6]  = '{3'b001, 16'h8011, 16'h0204, 3'b001, 3'b001, 1'b1, 16'h0102};
    tbl[7]  = '{3'b010, 16'h8011, 16'h0204, 3'b001, 3'b001, 1'b1, 16'h8011};
    tbl[8]  = '{3'b010, 16'h8011, 16'h0204, 3'b001, 3'b001, 1'b0, 16'h8011};
    tbl[9]  = '{3'b011, 16'h8012, 16'h0204, 3'b001, 3'b001, 1'b0, 16'h8011};
    tbl[10] = '{3'b011, 16'h0013, 16'h0204, 3'b001, 3'b001, 1'b1, 16'h8012};
    tbl[11] = '{3'b010, 16'h0013, 16'h0204, 3'b010, 3'b010, 1'b1, 16'h0013};
    tbl[12] = '{3'b000, 16'h0013, 16'h0204, 3'b000, 3'b000, 1'b1, 16'h0204};
    tbl[13] = '{3'b000, 16'h0013, 16'h0204, 3'b000, 3'b000, 1'b0, 16'h0204};

    rst = 1'b1; clr = 1'b0; ordy = 1'b1; v = 3'b001;
    for (int i = 0; i < NREQ; i++) d[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_grant", 32'(grant_o), 32'd0);
    check("reset_ready", 32'(req_ready_o), 32'd0);
    check("reset_out_valid", 32'(out_valid_o), 32'd0);
    check("reset_out_data", 32'(out_data_o), 32'd0);
    check("reset_abort", 32'(burst_abort_o), 32'd0);
    model_reset();
    rst = 1'b0; v = '0;

    for (int r = 0; r < 14; r++) begin
      v = tbl[r].valid; d[0] = tbl[r].d0; d[1] = tbl[r].d1; d[2] = '0;
      #1;
      check($sformatf("tbl%0d_grant", r), 32'(grant_o), 32'(tbl[r].exp_grant));
      check($sformatf("tbl%0d_ready", r), 32'(req_ready_o), 32'(tbl[r].exp_ready));
      check($sformatf("tbl%0d_out_valid", r), 32'(out_valid_o), 32'(tbl[r].exp_ov));
      check($sformatf("tbl%0d_out_data", r), 32'(out_data_o), 32'(tbl[r].exp_od));
      check($sformatf("tbl%0d_abort", r), 32'(burst_abort_o), 32'd0);
      cycle();
    end

    // Watchdog: req0 never ends its burst; the 4th packet forces a release.
    v = 3'b001; d[0] = 16'h8021;
    cycle();
    for (int p = 2; p <= MAXB; p++) begin
      v = 3'b011; d[0] = 16'(16'h8020 + p); d[1] = 16'h0331;
      cycle();
    end
    check("wd_abort_set", 32'(burst_abort_o), 32'd1);
    d[0] = 16'h8025;
    #1;
    check("wd_req1_next", 32'(grant_o), 32'b010);
    cycle();
    clr = 1'b1; v = 3'b000;
    cycle();
    clr = 1'b0;
    check("wd_abort_clr", 32'(burst_abort_o), 32'd0);

    // Back-pressure: hold one packet for 5 cycles, then stream at full rate.
    v = 3'b001; d[0] = 16'h0041;
    cycle();
    ordy = 1'b0; v = 3'b011; d[0] = 16'h0042; d[1] = 16'h0051;
    for (int c = 0; c < 5; c++) begin
      cycle();
      check("bp_data_stable", 32'(out_data_o), 32'h0041);
      check("bp_no_ready", 32'(req_ready_o), 32'd0);
    end
    ordy = 1'b1;
    for (int c = 0; c < 8; c++) begin
      cycle();
      check("bp_throughput", 32'(out_valid_o), 32'd1);
      for (int i = 0; i < NREQ; i++) if (last_acc[i]) d[i] = d[i] + 16'd1;
    end

    // Reset while locked with a packet in the output register.
    v = 3'b001; d[0] = 16'h8061;
    cycle();
    check("rst_pre_out_valid", 32'(out_valid_o), 32'd1);
    rst = 1'b1; v = 3'b000;
    cycle();
    check("rst_out_valid", 32'(out_valid_o), 32'd0);
    check("rst_out_data", 32'(out_data_o), 32'd0);
    check("rst_grant", 32'(grant_o), 32'd0);
    check("rst_abort", 32'(burst_abort_o), 32'd0);
    rst = 1'b0; v = 3'b010; d[1] = 16'h0071;
    #1;
    check("rst_idle_grant", 32'(grant_o), 32'b010);
    cycle();

    // Randomized traffic against the model.
    v = '0;
    for (int c = 0; c < 1500; c++) begin
      ordy = ($urandom_range(0, 99) < 75);
      clr  = ($urandom_range(0, 99) < 5);
      rst  = ($urandom_range(0, 199) == 0);
      cycle();
      for (int i = 0; i < NREQ; i++) begin
        if (!v[i] || last_acc[i]) begin
          v[i] = ($urandom_range(0, 99) < 60);
          d[i] = {1'($urandom_range(0, 1)), 15'($urandom_range(0, 32767))};
        end else if ($urandom_range(0, 99) < 3) begin
          v[i] = 1'b0;
        end
      end
    end

    rst = 1'b0; clr = 1'b0; ordy = 1'b1; v = '0;
    repeat (3) cycle();
    check("drain_out_valid", 32'(out_valid_o), 32'd0);
    check("drain_scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
